// File: rtl/inta_sequencer.sv
// 8259 interrupt-acknowledge sequencer (8086 mode): raises INT, tracks the
// two INTA pulses, latches the winning IR, pulses ISR-set/IRR-clear, drives
// the master cascade ID and the vector byte, and issues automatic EOI.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   inta_n            CPU INTA pin (active-low, asynchronous)
//   int_req, int_id   priority resolver request and winning IR
//   icw2_base         ICW2 T7..T3
//   icw3_slaves       master ICW3 (bit n = IRn has a slave)
//   sngl, sp, aeoi    ICW1 SNGL, SP/EN pin, ICW4 AEOI
//   vec_flag          cascade stage: slave ID matches casc lines
//   int_out           INT to CPU
//   isr_set, irr_clr  one-cycle pulses for bit isr_id
//   isr_id            latched IR number
//   auto_eoi          one-cycle pulse: clear ISR bit isr_id
//   casc_out, casc_oe cascade ID and master drive enable
//   data_out, data_oe vector byte and data bus drive enable
//   busy              sequencer not idle
module inta_sequencer #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] SPURIOUS_ID = 3'd7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inta_n,
    input  logic       int_req,
    input  logic [2:0] int_id,
    input  logic [4:0] icw2_base,
    input  logic [7:0] icw3_slaves,
    input  logic       sngl,
    input  logic       sp,
    input  logic       aeoi,
    input  logic       vec_flag,
    output logic       int_out,
    output logic       isr_set,
    output logic       irr_clr,
    output logic [2:0] isr_id,
    output logic       auto_eoi,
    output logic [2:0] casc_out,
    output logic       casc_oe,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, WAIT1, PULSE1, WAIT2, PULSE2
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sync;
    logic fall, rise, master, slave;
    logic spur, spur_n;
    logic int_out_n, isr_set_n, irr_clr_n, auto_eoi_n;
    logic casc_oe_n, data_oe_n;
    logic [2:0] isr_id_n, casc_out_n, latch_id;
    logic [7:0] data_out_n;

    // Flops preset high so reset never looks like an INTA edge.
    always_ff @(posedge clk) begin
        if (reset) sync <= '1;
        else       sync <= {sync[SYNC_STAGES-2:0], inta_n};
    end

    assign fall   = sync[SYNC_STAGES-1] & ~sync[SYNC_STAGES-2];
    assign rise   = ~sync[SYNC_STAGES-1] & sync[SYNC_STAGES-2];
    assign master = ~sngl & sp;
    assign slave  = ~sngl & ~sp;
    assign busy   = (state != IDLE);

    // A request that vanished before the first INTA is reported as IR7.
    assign latch_id = int_req ? int_id : SPURIOUS_ID;

    always_comb begin
        state_n    = state;
        spur_n     = spur;
        int_out_n  = int_out;
        isr_set_n  = 1'b0;
        irr_clr_n  = 1'b0;
        auto_eoi_n = 1'b0;
        isr_id_n   = isr_id;
        casc_out_n = casc_out;
        casc_oe_n  = casc_oe;
        data_out_n = data_out;
        data_oe_n  = data_oe;
        unique case (state)
            IDLE: begin
                int_out_n = int_req;
                if (int_req) state_n = WAIT1;
            end
            WAIT1: begin
                int_out_n = 1'b1;
                if (fall) begin
                    isr_id_n = latch_id;
                    spur_n   = ~int_req;
                    if (master) begin
                        casc_oe_n  = 1'b1;
                        casc_out_n = icw3_slaves[latch_id]
                                     ? latch_id : 3'd0;
                    end
                    state_n = PULSE1;
                end
            end
            PULSE1: begin
                if (rise) begin
                    if (slave && !vec_flag) begin
                        // Another slave owns this cycle.
                        state_n = IDLE;
                    end else begin
                        int_out_n = 1'b0;
                        isr_set_n = ~spur;
                        irr_clr_n = ~spur;
                        state_n   = WAIT2;
                    end
                end
            end
            WAIT2: begin
                if (fall) begin
                    data_out_n = {icw2_base, isr_id};
                    // A cascaded slave supplies the vector itself.
                    data_oe_n  = ~(master & icw3_slaves[isr_id]);
                    state_n    = PULSE2;
                end
            end
            PULSE2: begin
                if (rise) begin
                    data_oe_n  = 1'b0;
                    casc_oe_n  = 1'b0;
                    casc_out_n = 3'd0;
                    auto_eoi_n = aeoi & ~spur;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            spur     <= 1'b0;
            int_out  <= 1'b0;
            isr_set  <= 1'b0;
            irr_clr  <= 1'b0;
            auto_eoi <= 1'b0;
            isr_id   <= 3'd0;
            casc_out <= 3'd0;
            casc_oe  <= 1'b0;
            data_out <= 8'd0;
            data_oe  <= 1'b0;
        end else begin
            state    <= state_n;
            spur     <= spur_n;
            int_out  <= int_out_n;
            isr_set  <= isr_set_n;
            irr_clr  <= irr_clr_n;
            auto_eoi <= auto_eoi_n;
            isr_id   <= isr_id_n;
            casc_out <= casc_out_n;
            casc_oe  <= casc_oe_n;
            data_out <= data_out_n;
            data_oe  <= data_oe_n;
        end
    end

endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- Interrupt-acknowledge sequencer of the 8259 PIC, 8086 mode.
- Sits between the priority resolver (supplies int_req/int_id) and the cascade stage (consumes intrID via casc_out; supplies vec_flag).
- Raises INT, tracks the two INTA pulses, latches the winning IR, and pulses ISR-set/IRR-clear.
- Drives the cascade ID (master), places the vector byte on the data bus, and issues automatic EOI.

Parameters:
- SYNC_STAGES, 2, flops in the inta_n synchronizer (>=2)
- SPURIOUS_ID, 3'd7, IR reported when the request has vanished by the first INTA

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- inta_n  in  1  CPU INTA pin, active-low, asynchronous to clk
- int_req  in  1  resolver: unmasked request of higher priority than in-service
- int_id  in  3  resolver: winning IR number
- icw2_base  in  5  ICW2 T7..T3
- icw3_slaves  in  8  master ICW3: bit n=1 means IRn has a slave
- sngl  in  1  ICW1 SNGL (1 = single PIC)
- sp  in  1  SP/EN pin (1 = master)
- aeoi  in  1  ICW4 AEOI
- vec_flag  in  1  cascade stage: slave ID matches casc lines
- int_out  out  1  INT to CPU
- isr_set  out  1  one-cycle pulse: set ISR bit isr_id
- irr_clr  out  1  one-cycle pulse: clear IRR bit isr_id
- isr_id  out  3  latched IR number
- auto_eoi  out  1  one-cycle pulse: clear ISR bit isr_id
- casc_out  out  3  cascade ID to cascade stage
- casc_oe  out  1  master drives casc lines
- data_out  out  8  vector byte
- data_oe  out  1  drive data bus
- busy  out  1  state != IDLE

Behaviour:
- Reset:
  - all outputs 0; state IDLE.
  - Synchronizer flops preset to 1 (inta deasserted).
  - Reset in any state aborts the sequence with no pulses.
- INTA synchronization:
  - fall/rise are one-cycle pulses from the last two sync flops.
  - Detection is SYNC_STAGES cycles after the pin edge.
- Modes:
  - single = sngl
  - master = !sngl & sp
  - slave = !sngl & !sp
- States: IDLE, WAIT1, PULSE1, WAIT2, PULSE2.
- IDLE:
  - int_out = int_req (registered; 1-cycle latency).
  - int_req=1 -> WAIT1.
  - A slave waits here too; its INT feeds the master IR.
- WAIT1:
  - int_out=1.
  - fall -> PULSE1: latch isr_id = int_req ? int_id : SPURIOUS_ID; latch spurious flag = !int_req.
  - int_req dropping before fall does not leave WAIT1.
- PULSE1 (master/single):
  - Master: casc_oe=1 throughout PULSE1..PULSE2. casc_out = icw3_slaves[isr_id] ? isr_id : 0.
  - Single: casc_oe=0.
  - On rise: int_out<=0; if not spurious, pulse isr_set and irr_clr together (one cycle); -> WAIT2.
- PULSE1 (slave):
  - selected = vec_flag sampled on the rise cycle.
  - selected=0 -> IDLE, no pulses, int_out unchanged.
  - selected=1 -> same pulses as master, -> WAIT2.
- WAIT2:
  - fall -> PULSE2.
  - No timeout.
  - reset is the only abort.
- PULSE2:
  - data_out = {icw2_base, isr_id}.
  - data_oe=1 while in PULSE2, except a master whose isr_id has a slave (the slave drives data instead).
  - On rise:
    - data_oe<=0, casc_oe<=0, casc_out<=0.
    - If aeoi and not spurious, pulse auto_eoi (isr_id held valid in that cycle).
    - -> IDLE.
- Spurious: the vector is still driven as IR7 in PULSE2; no isr_set/irr_clr/auto_eoi.
- Simultaneous events:
  - New int_req or int_id changes after the PULSE1 latch are ignored until IDLE.
  - fall in IDLE/PULSE* is ignored; rise in WAIT* is ignored.
- Earliest re-assertion of int_out: the cycle after returning to IDLE.
- isr_id holds its value until the next latch.

Test Plan:
- Single, icw2_base=5'h08, int_req=1, int_id=3, two INTA pulses -> int_out=1 in 1 cycle; isr_set+irr_clr with isr_id=3 at first rise+2; data_oe=1, data_out=8'h43 during second pulse; casc_oe=0.
- Master, icw3_slaves=8'h04, int_id=2 -> casc_out=2, casc_oe=1 from first fall to second rise; data_oe stays 0; isr_set pulses; IR5 non-slave repeat gives casc_out=0, data_out={base,3'd5}.
- Slave, vec_flag=0 at first rise -> back to IDLE, no pulses, data_oe=0; repeat with vec_flag=1 -> vector driven on second pulse.
- int_req dropped to 0 before first fall -> isr_id=7, no isr_set/irr_clr/auto_eoi, data_out={base,3'b111}.
- aeoi=1, int_id=6 -> single auto_eoi pulse with isr_id=6 at second rise+2; busy falls same cycle.
- Reset asserted in WAIT2 -> next cycle all outputs 0, IDLE; a following INTA pulse produces nothing unless int_req is set.
